// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for the receive and transmit paths
// Contents:
//   DEFAULT_CLKS_PER_BIT : clk cycles per bit at 100 MHz / 9600 baud
//   DATA_BITS            : data bits per 8N1 frame
//   uart_state_t         : byte FSM state encoding
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 10417;
  localparam int DATA_BITS            = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte receiver: synchroniser, byte FSM and baud counter
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   rx_serial   : raw UART line, idle high, asynchronous to clk
//   byte_data   : received byte (valid while byte_done is high)
//   byte_done   : high in the stop-bit sample cycle when the stop bit is high
//   frame_err   : high in the stop-bit sample cycle when the stop bit is low
//   in_frame    : FSM is not in IDLE
//   start_det   : FSM is in IDLE and the synchronised line is low
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] byte_data,
  output logic                 byte_done,
  output logic                 frame_err,
  output logic                 in_frame,
  output logic                 start_det
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  uart_state_t          state, state_next;
  logic                 sync1, line;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 sample_tick;

  // Both flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      line  <= 1'b1;
    end else begin
      sync1 <= rx_serial;
      line  <= sync1;
    end
  end

  // Mid-start sample comes after half a bit; every later sample a full bit after the previous one.
  assign sample_tick = ((state == ST_START) && (cnt == HALF_LAST)) ||
                       (((state == ST_DATA) || (state == ST_STOP)) && (cnt == FULL_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state <= state_next;
      if ((state == ST_IDLE) || (state == ST_WAIT_HIGH) || sample_tick)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (state == ST_START) begin
        bit_idx <= '0;
      end else if ((state == ST_DATA) && sample_tick) begin
        bit_idx <= bit_idx + 1'b1;
        shreg   <= {line, shreg[DATA_BITS-1:1]};
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (!line) state_next = ST_START;
      ST_START:     if (sample_tick) state_next = line ? ST_IDLE : ST_DATA;
      ST_DATA:      if (sample_tick && (bit_idx == BIT_LAST)) state_next = ST_STOP;
      ST_STOP:      if (sample_tick) state_next = line ? ST_IDLE : ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (line) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_data = shreg;
    byte_done = (state == ST_STOP) && sample_tick && line;
    frame_err = (state == ST_STOP) && sample_tick && !line;
    in_frame  = (state != ST_IDLE);
    start_det = (state == ST_IDLE) && !line;
  end

endmodule

// File: rtl/uart_rx_2byte.sv
// rtl/uart_rx_2byte.sv - UART receiver assembling byte pairs into 16-bit words
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   Rx_Serial     : UART line, idle high
//   Rx_Word       : last completed word {byte1, byte2}, held until the next one
//   Rx_Word_Valid : one-cycle strobe when Rx_Word updates
//   Frame_Error   : one-cycle strobe when a stop bit samples low
//   Timeout_Error : one-cycle strobe when byte 2 does not start in time
//   Busy          : byte receiver is between start edge and return to IDLE
module uart_rx_2byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Rx_Serial,
  output logic [15:0] Rx_Word,
  output logic        Rx_Word_Valid,
  output logic        Frame_Error,
  output logic        Timeout_Error,
  output logic        Busy
);

  localparam int LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW    = $clog2(LIMIT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(LIMIT - 1);

  logic [DATA_BITS-1:0] byte_data;
  logic                 byte_done, frame_err, in_frame, start_det;
  logic                 byte_idx;
  logic [DATA_BITS-1:0] high_byte;
  logic [TW-1:0]        tcnt;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_byte (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_serial (Rx_Serial),
    .byte_data (byte_data),
    .byte_done (byte_done),
    .frame_err (frame_err),
    .in_frame  (in_frame),
    .start_det (start_det)
  );

  assign Busy = in_frame;

  // byte_done/frame_err only occur while in_frame, so they never collide with
  // the timeout branch, which runs only while the byte FSM is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Rx_Word       <= '0;
      Rx_Word_Valid <= 1'b0;
      Frame_Error   <= 1'b0;
      Timeout_Error <= 1'b0;
      byte_idx      <= 1'b0;
      high_byte     <= '0;
      tcnt          <= '0;
    end else begin
      Rx_Word_Valid <= 1'b0;
      Frame_Error   <= 1'b0;
      Timeout_Error <= 1'b0;

      if (frame_err) begin
        Frame_Error <= 1'b1;
        byte_idx    <= 1'b0;
        high_byte   <= '0;
      end else if (byte_done) begin
        if (!byte_idx) begin
          high_byte <= byte_data;
          byte_idx  <= 1'b1;
        end else begin
          Rx_Word       <= {high_byte, byte_data};
          Rx_Word_Valid <= 1'b1;
          byte_idx      <= 1'b0;
        end
      end

      // Expiry wins over a coincident start edge; that start then becomes byte 1 of a new word.
      if (byte_idx && !in_frame) begin
        if (tcnt == T_LAST) begin
          Timeout_Error <= 1'b1;
          byte_idx      <= 1'b0;
          high_byte     <= '0;
          tcnt          <= '0;
        end else if (start_det) begin
          tcnt <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

endmodule

// File: doc/uart_rx_2byte.md
# uart_rx_2byte

Receive-side counterpart of the design's two-byte UART transmitter: deserialises 8N1 UART frames from a host and assembles consecutive byte pairs into 16-bit words (first byte received = high byte). It sits between the board's UART RX pin and the host-command logic that drives the accelerometer control settings. It validates start and stop bits, discards partial words on error or inter-byte timeout, and presents each completed word with a one-cycle valid strobe.

## Interface
- CLKS_PER_BIT, 10417, clk cycles per UART bit (100 MHz / 9600 baud); must be ≥ 4.
- TIMEOUT_BITS, 20, max idle bit-times allowed between stop bit of byte 1 and start edge of byte 2.

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Rx_Serial  in  1  UART line, idle high, asynchronous to clk.
- Rx_Word  out  16  last completed word {byte1, byte2}; held until the next word completes.
- Rx_Word_Valid  out  1  one-cycle pulse when Rx_Word updates.
- Frame_Error  out  1  one-cycle pulse when a stop bit samples low.
- Timeout_Error  out  1  one-cycle pulse when byte 2 does not start in time.
- Busy  out  1  high from detected start edge until return to IDLE.

## Operation
- Rx_Serial passes through a 2-FF synchroniser; both flops reset to 1. All references to "line" below mean the synchronised value.
- Byte FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: line low → START, clear baud counter.
  - START: wait CLKS_PER_BIT/2 (integer division) cycles, then re-sample. Low → DATA. High → false start, back to IDLE with no output.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first, into a shift register.
  - STOP: sample after CLKS_PER_BIT cycles. High → byte done, go to IDLE. Low → pulse Frame_Error, discard the partial word (byte index := 0), go to WAIT_HIGH.
  - WAIT_HIGH: remain until line is high, then IDLE. This absorbs break conditions.
- Word assembly:
  - Byte index 0: a completed byte is stored as the high byte; index := 1; the timeout counter starts.
  - Byte index 1: a completed byte forms Rx_Word = {high, low} and pulses Rx_Word_Valid; index := 0.
- Timeout:
  - While index = 1 and the FSM is in IDLE, the counter increments each cycle.
  - When it reaches TIMEOUT_BITS*CLKS_PER_BIT: pulse Timeout_Error, index := 0, clear the high byte.
  - A start edge stops and clears the counter.
- Simultaneous events: a start edge detected in the same cycle the timeout expires is treated as the first byte of a new word. Timeout_Error still pulses.
- Reset values: Rx_Word = 16'h0000, Rx_Word_Valid = 0, Frame_Error = 0, Timeout_Error = 0, Busy = 0, FSM = IDLE, index = 0, counters = 0.
- Reset asserted mid-frame aborts immediately; the partial byte or word is discarded.

## Timing
- Cycle 0 is the first cycle the synchronised line is low in IDLE. Mid-start sample at cycle CLKS_PER_BIT/2.
- Data bit k (k = 0..7) is sampled at cycle CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT. The stop bit is sampled at CLKS_PER_BIT/2 + 9*CLKS_PER_BIT.
- Rx_Word_Valid and Frame_Error assert on the cycle after the stop-bit sample, for exactly 1 cycle. Rx_Word is valid in the same cycle as the strobe.
- Pin-to-line latency is 2 cycles (synchroniser).
- Back-to-back frames (next start bit immediately after the stop bit) must be received without loss. The FSM re-enters IDLE at mid-stop, so it has half a bit of margin.
- There is no ready/backpressure: the consumer must capture Rx_Word on the strobe.

## Structure
- Shared package (uart_pkg): FSM state encoding, default CLKS_PER_BIT, data-bit count constant (8). The same package is to be shared with the transmitter.
- Sub-module uart_rx_byte: synchroniser, byte FSM and baud counter. Outputs byte_data, byte_done pulse, frame_err pulse and an in_frame flag.
- The top level adds the byte index, high-byte register, timeout counter and output registers.

## Test plan
All scenarios use CLKS_PER_BIT = 16, TIMEOUT_BITS = 4.
- Send 0xA5 then 0x3C back-to-back → one Rx_Word_Valid pulse, Rx_Word = 16'hA53C; Frame_Error and Timeout_Error stay 0.
- Drive a 5-cycle low glitch on idle line → no strobes, Busy returns to 0 within 8 cycles, next pair 0x01,0x02 → 16'h0102.
- Send 0x55 with stop bit = 0 → Frame_Error pulse, no Rx_Word_Valid; line high, then 0xBE,0xEF → 16'hBEEF.
- Send 0x12, idle 100 cycles → Timeout_Error pulse at 64 idle cycles; then 0x34,0x56 → 16'h3456.
- Assert rst_n low during bit 3 of byte 2 of a pair → all outputs at reset values, Rx_Word = 0; after release, 0xCA,0xFE → 16'hCAFE.
- Stream 4 words with zero gap (0x0000, 0xFFFF, 0x8001, 0x7FFE) → 4 valid pulses with matching values in order.
